// File: rtl/regfile.sv
// ============================================================================
// regfile -- multi-entry register file with a hardware clear sequencer
//
// Purpose:
//   General-purpose register store for the CPU. Writeback uses the single
//   synchronous write port. Decode uses the two combinational read ports.
//   A clear sequencer zeroes every entry, one entry per clock, on request.
//
// Parameters:
//   WIDTH    : data width of each entry in bits
//   ADDR_W   : address width; DEPTH = 2**ADDR_W entries
//   ZERO_REG : 1 = entry 0 is hardwired to zero (not stored),
//              0 = entry 0 is an ordinary register
//
// Configuration macro:
//   REGFILE_BYPASS_EN : when defined, a write that is accepted in a cycle is
//                       forwarded combinationally to any read port that
//                       addresses the same entry in that cycle. This does not
//                       apply to hardwired entry 0 or during a clear.
//                       When undefined, a read during a same-address write
//                       returns the old value until the clock edge.
//
// Ports:
//   clk      in   system clock; all state updates on the rising edge
//   rst      in   asynchronous active-high reset
//   we       in   write enable, sampled on the rising edge
//   waddr    in   write address   [ADDR_W]
//   wdata    in   write data      [WIDTH]
//   raddr_a  in   read port A address
//   rdata_a  out  read port A data (combinational)
//   raddr_b  in   read port B address
//   rdata_b  out  read port B data (combinational)
//   clr      in   single-cycle request to start the clear sequence
//   busy     out  high while the clear sequence runs; writes are ignored
// ============================================================================
module regfile #(
   parameter int WIDTH    = 8,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   output logic [WIDTH-1:0]  rdata_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_b,
   input  logic              clr,
   output logic              busy
);

   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] cnt_reg;
   logic [ADDR_W-1:0] cnt_next;

   // A write is accepted only from IDLE when no clear is being requested in
   // the same cycle, so clr always wins over we.
   logic              wr_go;

   // Current contents of every entry, as seen by the read ports.
   logic [WIDTH-1:0]  entry [DEPTH];

   // ------------------------------------------------------------------------
   // Clear sequencer: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // ------------------------------------------------------------------------
   // Clear sequencer: next state and write qualification
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      wr_go      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (clr) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end else begin
               wr_go = we;
            end
         end
         CLEAR: begin
            // The counter wraps naturally. Leaving CLEAR is decided by
            // comparing against the last index, not by detecting overflow.
            // A clr seen here is ignored, so the sequence never restarts.
            cnt_next = cnt_reg + ADDR_W'(1);
            if (cnt_reg == LAST_IDX) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign busy = (state_reg == CLEAR);

   // ------------------------------------------------------------------------
   // Storage: one register per entry. The asynchronous reset must zero every
   // entry at once, so the storage is built from flops rather than a RAM.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         if (ZERO_REG != 0 && gi == 0) begin : g_zero
            // Hardwired zero: there is no storage, so writes vanish.
            assign entry[gi] = '0;
         end else begin : g_store
            logic [WIDTH-1:0] data_reg;

            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  data_reg <= '0;
               end else if (busy && (cnt_reg == ADDR_W'(gi))) begin
                  data_reg <= '0;
               end else if (wr_go && (waddr == ADDR_W'(gi))) begin
                  data_reg <= wdata;
               end
            end

            assign entry[gi] = data_reg;
         end
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Read ports: purely combinational, no clock latency.
   // ------------------------------------------------------------------------
   logic [ADDR_W-1:0] raddr_x [2];
   logic [WIDTH-1:0]  rdata_x [2];

   assign raddr_x[0] = raddr_a;
   assign raddr_x[1] = raddr_b;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rport
         logic [WIDTH-1:0] rd;

         always_comb begin
            rd = entry[raddr_x[gi]];
`ifdef REGFILE_BYPASS_EN
            // wr_go already excludes CLEAR and a same-cycle clr. The
            // hardwired zero entry must never show the write data.
            if (wr_go && (raddr_x[gi] == waddr) &&
                !((ZERO_REG != 0) && (waddr == '0))) begin
               rd = wdata;
            end
`endif
            // Force zero while reset is held. This keeps the outputs clean
            // even before the reset has finished propagating through the
            // storage.
            if (rst) begin
               rd = '0;
            end
         end

         assign rdata_x[gi] = rd;
      end
   endgenerate

   assign rdata_a = rdata_x[0];
   assign rdata_b = rdata_x[1];

endmodule

// File: tb/tb_regfile.sv
// ============================================================================
// tb_regfile -- self-checking bench for regfile
//
// A reference model keeps the register contents as a plain array. It also
// tracks the clear sequence as "busy / next entry to zero". Each step, the
// bench drives the inputs just after a rising edge. It checks both read ports
// and busy one time unit later. It then updates the model and waits for the
// next edge.
// ============================================================================
module tb_regfile;

   localparam int WIDTH    = 8;
   localparam int ADDR_W   = 3;
   localparam int ZERO_REG = 1;
   localparam int DEPTH    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              we = 1'b0;
   logic              clr = 1'b0;
   logic [ADDR_W-1:0] waddr = '0;
   logic [WIDTH-1:0]  wdata = '0;
   logic [ADDR_W-1:0] raddr_a = '0;
   logic [ADDR_W-1:0] raddr_b = '0;
   logic [WIDTH-1:0]  rdata_a;
   logic [WIDTH-1:0]  rdata_b;
   logic              busy;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   logic [WIDTH-1:0] m [DEPTH];
   bit               mbusy = 1'b0;
   int               mclr  = 0;

   regfile #(
      .WIDTH    (WIDTH),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (raddr_a),
      .rdata_a (rdata_a),
      .raddr_b (raddr_b),
      .rdata_b (rdata_b),
      .clr     (clr),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] exp_read(input logic [ADDR_W-1:0] a);
      if (rst) return '0;
      if (ZERO_REG != 0 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we && !mbusy && !clr && a == waddr) return wdata;
`endif
      return m[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m[i] = '0;
      mbusy = 1'b0;
      mclr  = 0;
   endtask

   // Apply the effect of the coming rising edge to the model.
   task automatic model_edge();
      if (rst) return;
      if (!mbusy) begin
         if (clr) begin
            mbusy = 1'b1;
            mclr  = 0;
         end else if (we && !(ZERO_REG != 0 && waddr == 0)) begin
            m[waddr] = wdata;
         end
      end else begin
         m[mclr] = '0;
         mclr++;
         if (mclr == DEPTH) mbusy = 1'b0;
      end
   endtask

   task automatic check(input string tag);
      logic [WIDTH-1:0] ea;
      logic [WIDTH-1:0] eb;
      logic             eby;
      ea  = exp_read(raddr_a);
      eb  = exp_read(raddr_b);
      eby = mbusy && !rst;
      compared++;
      assert (rdata_a === ea) else begin
         mismatched++;
         $error("FAIL %s rdata_a addr=%0d got=%h exp=%h", tag, raddr_a, rdata_a, ea);
      end
      compared++;
      assert (rdata_b === eb) else begin
         mismatched++;
         $error("FAIL %s rdata_b addr=%0d got=%h exp=%h", tag, raddr_b, rdata_b, eb);
      end
      compared++;
      assert (busy === eby) else begin
         mismatched++;
         $error("FAIL %s busy got=%b exp=%b", tag, busy, eby);
      end
      $display("[%0t] %s ra=%0d rd_a=%h rb=%0d rd_b=%h busy=%b", $time, tag,
               raddr_a, rdata_a, raddr_b, rdata_b, busy);
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      we = 1'b1; waddr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic scan(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         raddr_a = ADDR_W'(i);
         raddr_b = ADDR_W'(DEPTH - 1 - i);
         #1;
         check(tag);
         tick();
      end
   endtask

   // Run one clear sequence. The arguments are optional disturbances, given
   // as busy-cycle numbers where 0 means none: a write to entry 2, a second
   // clr, or an asynchronous reset. first_we adds a write to entry 4 in the
   // same cycle as the clr pulse.
   task automatic clear_run(input string tag, input bit first_we,
                            input int we_cyc, input int reclr_cyc, input int rst_cyc);
      int  n;
      bit  did_rst;
      n       = 0;
      did_rst = 1'b0;
      clr = 1'b1; we = first_we; waddr = 3'd4; wdata = 8'h77;
      #1;
      check({tag, "_start"});
      tick();
      clr = 1'b0; we = 1'b0;
      while (busy && n < 20) begin
         n++;
         raddr_a = ADDR_W'(n - 1);
         raddr_b = ADDR_W'(n);
         we      = (n == we_cyc);
         waddr   = 3'd2;
         wdata   = 8'h99;
         clr     = (n == reclr_cyc);
         #1;
         check(tag);
         if (n == rst_cyc) begin
            we = 1'b0; clr = 1'b0;
            rst = 1'b1;
            #1;
            model_reset();
            check({tag, "_rst_held"});
            #1;
            rst = 1'b0;
            #1;
            check({tag, "_rst_released"});
            did_rst = 1'b1;
            break;
         end
         tick();
         we = 1'b0; clr = 1'b0;
      end
      if (!did_rst) begin
         compared++;
         assert (n == DEPTH) else begin
            mismatched++;
            $error("FAIL %s busy_cycles got=%0d exp=%0d", tag, n, DEPTH);
         end
         $display("[%0t] %s busy_cycles=%0d", $time, tag, n);
      end
   endtask

   initial begin
      model_reset();

      // 1. Reset held: every address reads 0 and busy is low.
      #2;
      for (int i = 0; i < DEPTH; i++) begin
         raddr_a = ADDR_W'(i);
         raddr_b = ADDR_W'(i ^ 5);
         #1;
         check("reset_held");
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      scan("reset_scan");

      // 2. Basic writes and the hardwired zero entry.
      wr(3'd3, 8'hA5);
      wr(3'd7, 8'h5A);
      raddr_a = 3'd3; raddr_b = 3'd7;
      #1;
      check("write_read");
      wr(3'd0, 8'hFF);
      raddr_a = 3'd0; raddr_b = 3'd0;
      #1;
      check("zero_reg");

      // 3. Read during a write to the same address.
      wr(3'd5, 8'h11);
      raddr_a = 3'd5; raddr_b = 3'd5;
      we = 1'b1; waddr = 3'd5; wdata = 8'h3C;
      #1;
      check("rdw_before_edge");
      tick();
      we = 1'b0;
      check("rdw_after_edge");

      // 4. Fill the entries, clear them, and write into entry 2 mid-clear.
      for (int i = 1; i < DEPTH; i++) wr(ADDR_W'(i), WIDTH'(i));
      clear_run("clear_basic", 1'b0, 2, 0, 0);
      scan("after_clear");

      // 5. A clr and a write in the same cycle, then a second clr at busy
      //    cycle 3.
      for (int i = 1; i < DEPTH; i++) wr(ADDR_W'(i), WIDTH'(8'h20 + i));
      clear_run("clear_clr_we", 1'b1, 0, 3, 0);
      raddr_a = 3'd4; raddr_b = 3'd3;
      #1;
      check("clr_we_dropped");

      // 6. An asynchronous reset at busy cycle 4, then a write after it is
      //    released.
      for (int i = 1; i < DEPTH; i++) wr(ADDR_W'(i), WIDTH'(8'hC0 + i));
      clear_run("clear_rst", 1'b0, 0, 0, 4);
      scan("after_async_rst");
      wr(3'd6, 8'h42);
      raddr_a = 3'd6; raddr_b = 3'd1;
      #1;
      check("write_after_rst");

      // Random traffic with occasional clears.
      for (int k = 0; k < 400; k++) begin
         we      = 1'($urandom_range(0, 1));
         waddr   = ADDR_W'($urandom);
         wdata   = WIDTH'($urandom);
         raddr_a = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom);
         raddr_b = ADDR_W'($urandom);
         clr     = ($urandom_range(0, 29) == 0);
         #1;
         check("rand");
         tick();
      end
      we = 1'b0; clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
